// File: rtl/mode_input_ctrl.sv
// Button front-end for the LED pattern processor: 2-flop sync, debounce, mode/pause control, tick pacing.
// Press-to-output latency DEB_CYCLES+2 edges from first capture; no backpressure, outputs are free-running levels/strobes.
module mode_input_ctrl #(
   parameter int TICK_DIV   = 50000000,
   parameter int DEB_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_pause,
   output logic       tick,
   output logic       pause,
   output logic [1:0] mode,
   output logic       mode_change
);

   localparam int TW = ($clog2(TICK_DIV) < 1) ? 1 : $clog2(TICK_DIV);
   localparam int DW = ($clog2(DEB_CYCLES) < 1) ? 1 : $clog2(DEB_CYCLES);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

   // Bit 0 carries the mode button, bit 1 the pause button.
   localparam int BM = 0;
   localparam int BP = 1;

   logic [1:0]    s1_q, s1_d;
   logic [1:0]    s2_q, s2_d;
   logic [1:0]    deb_q, deb_d;
   logic [1:0]    press_q, press_d;
   logic [DW-1:0] deb_cnt_q [2];
   logic [DW-1:0] deb_cnt_d [2];

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick_q, tick_d;
   logic          pause_q, pause_d;
   logic [1:0]    mode_q, mode_d;
   logic          mode_change_q, mode_change_d;

   always_comb begin
      s1_d = {btn_pause, btn_mode};
      s2_d = s1_q;
      deb_d = deb_q;
      press_d = 2'b00;
      for (int i = 0; i < 2; i++) begin
         deb_cnt_d[i] = deb_cnt_q[i];
         if (s2_q[i] == deb_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] == DEB_LAST) begin
            deb_d[i]     = s2_q[i];
            deb_cnt_d[i] = '0;
            // Only a debounced rising level counts as a press.
            press_d[i]   = s2_q[i];
         end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      mode_d        = mode_q;
      pause_d       = pause_q;
      mode_change_d = 1'b0;
      if (tick_cnt_q == TICK_LAST) begin
         tick_cnt_d = '0;
         tick_d     = 1'b1;
      end else begin
         tick_cnt_d = tick_cnt_q + 1'b1;
         tick_d     = 1'b0;
      end
      // A mode press restarts the pattern: it clears pause and re-phases the tick, overriding a same-cycle pause press.
      if (press_q[BM]) begin
         mode_d        = mode_q + 2'd1;
         mode_change_d = 1'b1;
         pause_d       = 1'b0;
         tick_cnt_d    = '0;
         tick_d        = 1'b0;
      end else if (press_q[BP]) begin
         pause_d = ~pause_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1_q          <= 2'b00;
         s2_q          <= 2'b00;
         deb_q         <= 2'b00;
         press_q       <= 2'b00;
         deb_cnt_q[0]  <= '0;
         deb_cnt_q[1]  <= '0;
         tick_cnt_q    <= '0;
         tick_q        <= 1'b0;
         pause_q       <= 1'b0;
         mode_q        <= 2'd0;
         mode_change_q <= 1'b0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         deb_q         <= deb_d;
         press_q       <= press_d;
         deb_cnt_q[0]  <= deb_cnt_d[0];
         deb_cnt_q[1]  <= deb_cnt_d[1];
         tick_cnt_q    <= tick_cnt_d;
         tick_q        <= tick_d;
         pause_q       <= pause_d;
         mode_q        <= mode_d;
         mode_change_q <= mode_change_d;
      end
   end

   assign tick        = tick_q;
   assign pause       = pause_q;
   assign mode        = mode_q;
   assign mode_change = mode_change_q;

endmodule

// File: tb/tb_mode_input_ctrl.sv
// Bench for mode_input_ctrl with TICK_DIV=5, DEB_CYCLES=4: vector table plus event scoreboard
// for mode/pause updates and an independent tick-period tracker.
module tb_mode_input_ctrl;

   localparam int EV_NONE  = 0;
   localparam int EV_MODE  = 1;
   localparam int EV_PAUSE = 2;
   localparam int LAT      = 7;  // drive negedge -> capture edge (+1) -> output edge (+6)
   localparam int TPER     = 5;

   typedef struct {
      logic       bm;
      logic       bp;
      int         hold;
      int         ev;
      logic [1:0] exp_mode;
      logic       exp_pause;
   } vec_t;

   typedef struct {
      int         kind;
      int         edge_n;
      logic [1:0] mode;
      logic       pause;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_pause = 1'b0;
   logic       tick;
   logic       pause;
   logic [1:0] mode;
   logic       mode_change;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic rst_edge = 1'b1;
   int   next_tick = 0;
   logic [1:0] prev_mode = 2'd0;
   logic prev_pause = 1'b0;
   vec_t vecs[$];
   ev_t  sbq[$];

   mode_input_ctrl #(.TICK_DIV(5), .DEB_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_pause(btn_pause),
      .tick(tick), .pause(pause), .mode(mode), .mode_change(mode_change)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_edge <= ~reset;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic sb_pop(input int kind);
      ev_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_unexpected event kind %0d at edge %0d: got mode %0d pause %0d expected no event",
                  kind, cyc, mode, pause);
      end else begin
         e = sbq.pop_front();
         chk("ev_kind", 32'(kind), 32'(e.kind));
         chk("ev_edge", 32'(cyc), 32'(e.edge_n));
         chk("ev_mode", 32'(mode), 32'(e.mode));
         chk("ev_pause", 32'(pause), 32'(e.pause));
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic add(input logic bm, input logic bp, input int hold, input int ev,
                      input logic [1:0] m, input logic p);
      vec_t v;
      v.bm = bm; v.bp = bp; v.hold = hold; v.ev = ev; v.exp_mode = m; v.exp_pause = p;
      vecs.push_back(v);
   endtask

   task automatic expect_ev(input int kind, input logic [1:0] m, input logic p);
      ev_t e;
      e.kind = kind; e.edge_n = cyc + LAT; e.mode = m; e.pause = p;
      sbq.push_back(e);
   endtask

   // Output monitor: event scoreboard plus tick phase tracking.
   always @(negedge clk) begin
      if (rst_edge) begin
         chk("reset_outputs", 32'({tick, pause, mode, mode_change}), 32'd0);
         next_tick  = cyc + TPER;
         prev_mode  = 2'd0;
         prev_pause = 1'b0;
      end else begin
         if (mode_change === 1'b1) begin
            chk("mode_change_tick_low", 32'(tick), 32'd0);
            next_tick = cyc + TPER;
            sb_pop(EV_MODE);
         end else begin
            if (pause !== prev_pause) sb_pop(EV_PAUSE);
            if (mode !== prev_mode) chk("mode_without_strobe", 32'(mode), 32'(prev_mode));
            if (tick === 1'b1) begin
               chk("tick_phase", 32'(cyc), 32'(next_tick));
               next_tick = cyc + TPER;
            end else if (cyc == next_tick) begin
               chk("tick_missing", 32'(tick), 32'd1);
               next_tick = cyc + TPER;
            end
         end
         prev_mode  = mode;
         prev_pause = pause;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      // idle after reset: mode 0, pause 0, ticks only
      add(0, 0, 12, EV_NONE, 2'd0, 1'b0);
      // mode cycling 1,2,3,0; last press held long to rule out auto-repeat
      add(1, 0, 10, EV_MODE, 2'd1, 1'b0);  add(0, 0, 10, EV_NONE, 2'd1, 1'b0);
      add(1, 0, 10, EV_MODE, 2'd2, 1'b0);  add(0, 0, 10, EV_NONE, 2'd2, 1'b0);
      add(1, 0, 10, EV_MODE, 2'd3, 1'b0);  add(0, 0, 10, EV_NONE, 2'd3, 1'b0);
      add(1, 0, 25, EV_MODE, 2'd0, 1'b0);  add(0, 0, 10, EV_NONE, 2'd0, 1'b0);
      // pause toggle twice, 30 cycles apart
      add(0, 1, 10, EV_PAUSE, 2'd0, 1'b1); add(0, 0, 20, EV_NONE, 2'd0, 1'b1);
      add(0, 1, 10, EV_PAUSE, 2'd0, 1'b0); add(0, 0, 10, EV_NONE, 2'd0, 1'b0);
      // bounce: highs of 1,2,3 cycles rejected, then stable high
      add(0, 1, 1, EV_NONE, 2'd0, 1'b0);   add(0, 0, 1, EV_NONE, 2'd0, 1'b0);
      add(0, 1, 2, EV_NONE, 2'd0, 1'b0);   add(0, 0, 1, EV_NONE, 2'd0, 1'b0);
      add(0, 1, 3, EV_NONE, 2'd0, 1'b0);   add(0, 0, 1, EV_NONE, 2'd0, 1'b0);
      add(0, 1, 10, EV_PAUSE, 2'd0, 1'b1); add(0, 0, 10, EV_NONE, 2'd0, 1'b1);
      // reach mode 2 with pause 1 (mode press clears pause)
      add(1, 0, 10, EV_MODE, 2'd1, 1'b0);  add(0, 0, 10, EV_NONE, 2'd1, 1'b0);
      add(1, 0, 10, EV_MODE, 2'd2, 1'b0);  add(0, 0, 10, EV_NONE, 2'd2, 1'b0);
      add(0, 1, 10, EV_PAUSE, 2'd2, 1'b1); add(0, 0, 10, EV_NONE, 2'd2, 1'b1);
      // simultaneous presses: mode wins, pause forced low
      add(1, 1, 10, EV_MODE, 2'd3, 1'b0);  add(0, 0, 10, EV_NONE, 2'd3, 1'b0);

      reset = 1'b0;
      step(3);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         btn_mode  = vecs[i].bm;
         btn_pause = vecs[i].bp;
         if (vecs[i].ev != EV_NONE) expect_ev(vecs[i].ev, vecs[i].exp_mode, vecs[i].exp_pause);
         step(vecs[i].hold);
         chk($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].exp_mode));
         chk($sformatf("vec%0d_pause", i), 32'(pause), 32'(vecs[i].exp_pause));
      end

      // reset while mode button is mid-debounce (counter at 2), button released with reset
      btn_mode = 1'b1;
      step(4);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      btn_mode = 1'b0;
      step(12);
      chk("rst_mid_mode", 32'(mode), 32'd0);
      chk("rst_mid_pause", 32'(pause), 32'd0);

      // same, but button held through reset: needs a full fresh debounce window
      btn_mode = 1'b1;
      step(4);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      expect_ev(EV_MODE, 2'd1, 1'b0);
      step(10);
      btn_mode = 1'b0;
      step(10);
      chk("rst_held_mode", 32'(mode), 32'd1);

      step(5);
      chk("sb_drained", 32'(sbq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mode_input_ctrl.md
Name: mode_input_ctrl

Overview:
- Upstream front-end for the 4-mode LED pattern processor.
- Synchronises and debounces two raw push-buttons (mode select, pause).
- Produces, for the processor:
  - the 2-bit mode index;
  - a toggling pause level;
  - a one-cycle `mode_change` strobe;
  - the periodic one-cycle `tick` that paces pattern stepping.

Parameters:
- TICK_DIV, 50000000: clock cycles per tick period (≥2).
- DEB_CYCLES, 1000000: consecutive stable cycles required to accept a button level change (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- btn_mode  input  1  raw asynchronous mode button, active-high.
- btn_pause  input  1  raw asynchronous pause button, active-high.
- tick  output  1  one-cycle pulse every TICK_DIV cycles.
- pause  output  1  pause level; 1 = downstream holds pattern.
- mode  output  2  current mode index 0..3.
- mode_change  output  1  one-cycle strobe, coincident with each mode update.

Behaviour:
- Reset (reset==0 at a rising edge) clears every register:
  - outputs: tick=0, pause=0, mode=0, mode_change=0;
  - internals: sync flops, debounced levels, debounce counters, tick counter.
  - Reset takes priority over every other event, including mid-debounce and mid-tick-period.
- Synchroniser: each button passes through 2 flops (s1, s2).
- Debounce, per button:
  - Counter runs while s2 != deb and clears to 0 whenever s2 == deb.
  - When the counter equals DEB_CYCLES-1 and s2 != deb still holds, then on that edge: deb <= s2, counter <= 0.
  - A press pulse (internal, registered) is asserted on the same edge only when deb goes 0→1.
  - Glitches shorter than DEB_CYCLES cycles produce nothing.
  - Releases produce no pulse.
- Latency, counting the edge that first captures a high button into s1 as edge 0:
  - deb rises and the press pulse asserts at edge DEB_CYCLES+1.
  - The resulting output change occurs at edge DEB_CYCLES+2.
- Mode press, at the next edge:
  - mode <= mode+1, wrapping 3→0 (2-bit modulo).
  - mode_change <= 1 for exactly one cycle.
  - pause <= 0.
  - tick counter <= 0; tick <= 0 on that edge.
- Pause press, with no mode press in the same cycle: pause <= ~pause at the next edge. mode is unchanged.
- Simultaneous mode and pause presses in the same cycle: mode press wins; pause is forced to 0, not toggled.
- Tick generator:
  - Counter runs 0..TICK_DIV-1, then wraps to 0.
  - tick is registered; it is 1 for exactly the one cycle following the edge where the counter wraps from TICK_DIV-1 to 0.
  - Period is exactly TICK_DIV cycles.
  - The counter runs regardless of pause; downstream interprets pause.
  - After reset or a mode change, the first tick appears TICK_DIV cycles later.
- Held button: one press pulse per debounced 0→1 transition only. Holding a button never auto-repeats.
- Counter widths: $clog2(TICK_DIV) and $clog2(DEB_CYCLES), minimum 1 bit each. No overflow is possible because each counter clears at its terminal count.

Test Plan (TICK_DIV=5, DEB_CYCLES=4, clk period 20 ns):
- Reset / tick period:
  - Stimulus: hold reset=0 for 3 cycles, then release.
  - Response: during reset all outputs 0. After release, tick pulses high for 1 cycle every 5 cycles; the first pulse comes 5 cycles after release; mode=0 and pause=0 throughout.
- Mode cycling:
  - Stimulus: four clean btn_mode presses, each held 10 cycles with 10 cycles released between.
  - Response: mode steps 1,2,3,0. Each update lands 6 edges after the capture edge, with a 1-cycle mode_change at each update. The tick counter restarts, so the next tick is 5 cycles after each change.
- Pause toggle:
  - Stimulus: btn_pause pressed once, then again 30 cycles later.
  - Response: pause goes 0→1, then back to 0. mode is unchanged. tick keeps pulsing every 5 cycles while paused.
- Bounce rejection:
  - Stimulus: btn_pause toggled with high widths 1, 2, 3 cycles separated by 1-cycle lows, then held high 10 cycles.
  - Response: exactly one pause toggle, occurring 6 edges after the start of the stable high. No toggle occurs during the bounce.
- Simultaneous presses:
  - Stimulus: with pause=1 and mode=2, raise btn_mode and btn_pause on the same cycle.
  - Response: mode=3, pause=0, single mode_change pulse.
- Reset mid-operation:
  - Stimulus: assert reset=0 for 1 cycle while a button is mid-debounce (counter=2) and mode=3.
  - Response: after that edge mode=0, pause=0, tick=0. No press is generated unless the button then stays high a further full debounce window after release of reset.
